// File: rtl/smol_boi.sv
`timescale 1ns/1ps
// SPI-slave multiplier: receives operands A,B (MSB first) in one CS frame and returns A*B on MISO.
// Latency: product MSB on MISO 2 CLK after the last operand SCLK rise (plus 2-flop sync delay).
// No backpressure: the master paces everything with SCLK. Optional SMOLBOI_SIGNED_EN: signed multiply.
module smol_boi #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic CS,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [2:0] {IDLE, RX, CALC, TX, DONE} state_t;

  state_t          state, state_nxt;
  logic            cs_s1, cs_s2, sclk_s1, sclk_s2, sclk_d, mosi_s1, mosi_s2;
  logic [1:0]      sync_fill;
  logic            cs_armed;
  logic            sclk_rise, sclk_fall;
  logic [PW-1:0]   in_reg, tx_reg, prod, opa, opb;
  logic [CW-1:0]   bit_cnt;

  // cs_armed only rises once a settled CS=0 has been seen, so a CS held high through reset never starts a frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_s1     <= 1'b0;
      cs_s2     <= 1'b0;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      sync_fill <= 2'b00;
      cs_armed  <= 1'b0;
    end else begin
      cs_s1     <= CS;
      cs_s2     <= cs_s1;
      sclk_s1   <= SCLK;
      sclk_s2   <= sclk_s1;
      sclk_d    <= sclk_s2;
      mosi_s1   <= MOSI;
      mosi_s2   <= mosi_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      cs_armed  <= cs_armed | (sync_fill[1] & ~cs_s2);
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;

  always_comb begin
`ifdef SMOLBOI_SIGNED_EN
    opa = {{WIDTH{in_reg[PW-1]}}, in_reg[PW-1:WIDTH]};
    opb = {{WIDTH{in_reg[WIDTH-1]}}, in_reg[WIDTH-1:0]};
`else
    opa = {{WIDTH{1'b0}}, in_reg[PW-1:WIDTH]};
    opb = {{WIDTH{1'b0}}, in_reg[WIDTH-1:0]};
`endif
    prod = opa * opb;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cs_s2 && cs_armed) state_nxt = RX;
      RX:   if (sclk_rise && bit_cnt == CW'(PW - 1)) state_nxt = CALC;
      CALC: state_nxt = TX;
      TX:   if (sclk_fall && bit_cnt == CW'(PW)) state_nxt = DONE;
      DONE: if (!cs_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !cs_s2) state_nxt = IDLE;
  end

  // In TX bit_cnt counts output rises; the fall before the first output rise must not shift
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_reg  <= '0;
      tx_reg  <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_reg  <= '0;
          tx_reg  <= '0;
          bit_cnt <= '0;
        end
        RX: if (sclk_rise) begin
          in_reg  <= {in_reg[PW-2:0], mosi_s2};
          bit_cnt <= (bit_cnt == CW'(PW - 1)) ? '0 : bit_cnt + 1'b1;
        end
        CALC: begin
          tx_reg  <= prod;
          bit_cnt <= '0;
        end
        TX: begin
          if (sclk_rise && bit_cnt != CW'(PW)) bit_cnt <= bit_cnt + 1'b1;
          if (sclk_fall && bit_cnt != '0 && bit_cnt != CW'(PW))
            tx_reg <= {tx_reg[PW-2:0], 1'b0};
        end
        DONE: tx_reg <= '0;
        default: bit_cnt <= '0;
      endcase
    end
  end

  assign MISO = (state == TX) & tx_reg[PW-1];

endmodule

// File: tb/tb_smol_boi.sv
`timescale 1ns/1ps
// Bench for smol_boi: SPI master model driving directed and random frames, product checked against arithmetic.
module tb_smol_boi;

  localparam int HALF = 200;  // SCLK half period: 2.5 MHz against a 50 MHz CLK

  logic CLK = 1'b0;
  logic RST, CS, SCLK, MOSI, MISO;
  int   checks = 0;
  int   passes = 0;

  smol_boi #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
`ifdef SMOLBOI_SIGNED_EN
    ia = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    ib = (b >= 4'd8) ? int'(b) - 16 : int'(b);
`else
    ia = int'(a);
    ib = int'(b);
`endif
    return 8'(ia * ib);
  endfunction

  task automatic sclk_cycle(input logic mosi_bit, output logic miso_at_rise);
    MOSI = mosi_bit;
    #HALF SCLK = 1'b1;
    miso_at_rise = MISO;
    #HALF SCLK = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] word, got;
    logic       m, quiet, done_quiet;
    word  = {a, b};
    quiet = 1'b1;
    CS    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(word[7-i], m);
      if (m !== 1'b0) quiet = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(1'($urandom), m);
      got[7-i] = m;
    end
    check({tag, "_product"}, got, model(a, b));
    check({tag, "_rx_quiet"}, {7'd0, quiet}, 8'd1);
    #HALF;
    done_quiet = (MISO === 1'b0);
    for (int i = 0; i < 2; i++) begin
      sclk_cycle(1'b1, m);
      if (m !== 1'b0) done_quiet = 1'b0;
    end
    check({tag, "_done_quiet"}, {7'd0, done_quiet}, 8'd1);
    CS = 1'b0;
    #(2*HALF);
  endtask

  initial begin
    logic m, quiet;
    RST = 1'b1; CS = 1'b0; SCLK = 1'b0; MOSI = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("reset_miso", {7'd0, MISO}, 8'd0);
    RST = 1'b0;
    #(2*HALF);
    check("idle_miso", {7'd0, MISO}, 8'd0);

    do_frame("d_1x6",   4'h1, 4'h6);
    do_frame("d_15x15", 4'hF, 4'hF);
    do_frame("d_0x11",  4'h0, 4'hB);
    do_frame("d_15x2",  4'hF, 4'h2);

    // Abort after 5 operand bits, then SCLK noise with CS low
    CS = 1'b1;
    for (int i = 0; i < 5; i++) sclk_cycle(1'b1, m);
    CS = 1'b0;
    #(2*HALF);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(1'b1, m);
      if (m !== 1'b0) quiet = 1'b0;
    end
    check("cs_low_quiet", {7'd0, quiet}, 8'd1);
    do_frame("abort_3x5", 4'h3, 4'h5);

    // Reset during the third output bit of a 7x5 frame, CS left high across it
    CS = 1'b1;
    for (int i = 0; i < 8; i++) sclk_cycle((i == 1 || i == 2 || i == 3 || i == 5 || i == 7), m);
    sclk_cycle(1'b0, m);
    sclk_cycle(1'b0, m);
    MOSI = 1'b0;
    #HALF SCLK = 1'b1;
    check("rst_pre_bit", {7'd0, MISO}, 8'd1);
    RST = 1'b1;
    #20 RST = 1'b0;
    check("rst_miso", {7'd0, MISO}, 8'd0);
    #(HALF-20) SCLK = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sclk_cycle(1'($urandom), m);
      if (m !== 1'b0) quiet = 1'b0;
    end
    check("rst_cs_high_quiet", {7'd0, quiet}, 8'd1);
    CS = 1'b0;
    #(2*HALF);
    do_frame("post_rst_2x3", 4'h2, 4'h3);

    for (int n = 0; n < 20; n++) begin
      do_frame("rand", 4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/smol_boi.md
SMOL_BOI -- requirements
Module: smol_boi

Interface
REQ-001 WIDTH, default 4: operand width in bits; the product is 2*WIDTH bits.
REQ-002 CLK  input  1  system clock; all state updates on the CLK rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 CS  input  1  chip select, active-high; a frame runs while CS=1.
REQ-005 SCLK  input  1  SPI serial clock from the master, asynchronous to CLK.
REQ-006 MOSI  input  1  serial operand data, MSB first.
REQ-007 MISO  output  1  serial product data, MSB first; 0 when not transmitting.

Function
REQ-008 The block SHALL pass CS, SCLK and MOSI through a two-flop synchronizer to CLK and SHALL detect SCLK rise and fall edges on the synchronized signal.
REQ-009 The block SHALL require an SCLK period of at least 8 CLK periods; slower SCLK is fully supported.
REQ-010 The state machine SHALL have the states IDLE, RX, CALC, TX and DONE.
REQ-011 IDLE: MISO=0 and the counters are cleared; on synchronized CS=1 the state SHALL go to RX.
REQ-012 RX: on each SCLK rise, MOSI SHALL be shifted into a 2*WIDTH input register, MSB first.
REQ-013 RX: the first WIDTH bits form operand A and the next WIDTH bits form operand B; after bit 2*WIDTH the state SHALL go to CALC.
REQ-014 CALC: lasting one CLK cycle, the block SHALL load P=A*B (unsigned, 2*WIDTH bits, no overflow possible) into the TX shift register, then go to TX.
REQ-015 TX: MISO SHALL equal TX register MSB; P[2W-1] SHALL be valid within 2 CLK cycles of entering TX, well before the next SCLK rise.
REQ-016 TX: on each SCLK fall the register SHALL shift left by one; the master samples MISO on SCLK rise, so the 2*WIDTH rises after the last operand bit carry P MSB to LSB.
REQ-017 TX: after the SCLK fall that follows the 2*WIDTH-th output rise, the state SHALL go to DONE with MISO=0.
REQ-018 DONE: SCLK and MOSI SHALL be ignored until CS=0, then the state SHALL go to IDLE; a new product requires a new CS frame.
REQ-019 CS dropping in any state SHALL abort to IDLE within 3 CLK cycles, with MISO=0 and partial operands discarded.
REQ-020 SCLK edges while CS=0 SHALL have no effect.

Reset
REQ-021 While RST=1 at a CLK rise: state=IDLE; MISO=0; input, TX and synchronizer registers=0; bit counter=0.
REQ-022 RST SHALL take priority over CS and SCLK activity, including mid-RX or mid-TX.
REQ-023 After RST is released with CS already high, the block SHALL enter RX only on a CS 0->1 transition, not on a level-high CS.

Configuration
REQ-024 With SMOLBOI_SIGNED_EN defined: A and B are two's complement and P is the sign-correct 2*WIDTH-bit signed product.
REQ-025 Without SMOLBOI_SIGNED_EN: the multiply is unsigned.

Verification
REQ-026 CLK 50 MHz, SCLK 2.5 MHz, CS=1, MOSI 0001 then 0110 -> MISO over the next 8 SCLK rises 0,0,0,0,0,1,1,0.
REQ-027 Operands 1111 and 1111, unsigned build -> MISO 11100001; signed build -> 00000001.
REQ-028 Operands 0000 and 1011 -> MISO 00000000, and MISO=0 after the frame and in DONE.
REQ-029 CS dropped after 5 operand bits, then a new frame 0011 and 0101 -> MISO 00001111.
REQ-030 RST pulsed during bit 3 of TX -> MISO=0 next CLK; a later CS-toggled frame 0010 and 0011 -> MISO 00000110.
REQ-031 Signed build, operands 1111 and 0010 -> MISO 11111110.
